zap_store_aligner: RTL and testbench

ZAP_STORE_ALIGNER -- requirements
Module: zap_store_aligner

---
 rtl/zap_store_aligner.sv | 138 +++++++++++++
 tb/tb_zap_store_aligner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/zap_store_aligner.sv
// Store-buffer and Wishbone write aligner: formats byte/half/word stores into lane-selected words.
// Optional `ZAP_ARM60_BIG_ENDIAN_EN selects ARM60 big-endian byte lanes; default is little-endian.
module zap_store_aligner #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_st_valid,
  output logic        o_st_ready,
  input  logic [31:0] i_st_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_st_byte,
  input  logic        i_st_half,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic        o_fault,
  output logic [31:0] o_fault_addr,
  output logic        o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [29:0] wadr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } entry_t;

  function automatic entry_t format_store(input logic [31:0] addr, input logic [31:0] data,
                                          input logic byte_en, input logic half_en);
    entry_t e;
    e.wadr = addr[31:2];
    if (byte_en && !half_en) begin
      e.dat = {4{data[7:0]}};
`ifdef ZAP_ARM60_BIG_ENDIAN_EN
      e.sel = 4'b1000 >> addr[1:0];
`else
      e.sel = 4'b0001 << addr[1:0];
`endif
    end else if (half_en && !byte_en) begin
      e.dat = {2{data[15:0]}};
      e.sel = addr[1] ? 4'b1100 : 4'b0011;
    end else begin
      e.dat = data;
      e.sel = 4'b1111;
    end
    return e;
  endfunction

  state_t          state_q, state_d;
  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            fault_q, fault_d;
  logic [31:0]     fault_addr_q, fault_addr_d;
  logic            push, pop, busy;
  entry_t          head;

  assign busy       = (state_q == BUSY);
  assign head       = mem_q[rd_ptr_q];
  assign o_st_ready = (count_q < CW'(DEPTH));
  assign push       = i_st_valid && o_st_ready;
  assign pop        = busy && (i_wb_ack || i_wb_err);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Error wins over a simultaneous ack: the entry is dropped and reported, never retried.
    if (pop && i_wb_err) begin
      fault_d      = 1'b1;
      fault_addr_d = {head.wadr, 2'b00};
    end

    case (state_q)
      IDLE:    if (count_d != '0) state_d = BUSY;
      BUSY:    if (pop && count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // NOTE: buffer storage is deliberately not reset; the pointers and count define which slots are valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= format_store(i_st_addr, i_st_data, i_st_byte, i_st_half);
  end

  // Bus fields come straight from the head slot, so they stay stable until the entry pops.
  assign o_wb_cyc     = busy;
  assign o_wb_stb     = busy;
  assign o_wb_we      = busy;
  assign o_wb_adr     = busy ? {head.wadr, 2'b00} : 32'h0;
  assign o_wb_sel     = busy ? head.sel : 4'h0;
  assign o_wb_dat     = busy ? head.dat : 32'h0;
  assign o_fault      = fault_q;
  assign o_fault_addr = fault_addr_q;
  assign o_empty      = (count_q == '0) && !busy;

endmodule

// File: tb/tb_zap_store_aligner.sv
// Directed self-checking bench for zap_store_aligner (DEPTH=2): formatting, backpressure, errors, reset.
module tb_zap_store_aligner;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_st_valid;
  logic        o_st_ready;
  logic [31:0] i_st_addr;
  logic [31:0] i_st_data;
  logic        i_st_byte;
  logic        i_st_half;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_adr;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_dat;
  logic        i_wb_ack, i_wb_err;
  logic        o_fault;
  logic [31:0] o_fault_addr;
  logic        o_empty;

  int n_checks = 0;
  int n_errors = 0;

`ifdef ZAP_ARM60_BIG_ENDIAN_EN
  localparam logic [3:0] SEL_B0 = 4'b1000;
  localparam logic [3:0] SEL_B1 = 4'b0100;
  localparam logic [3:0] SEL_B3 = 4'b0001;
`else
  localparam logic [3:0] SEL_B0 = 4'b0001;
  localparam logic [3:0] SEL_B1 = 4'b0010;
  localparam logic [3:0] SEL_B3 = 4'b1000;
`endif

  zap_store_aligner #(.DEPTH(2)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_st_valid   (i_st_valid),
    .o_st_ready   (o_st_ready),
    .i_st_addr    (i_st_addr),
    .i_st_data    (i_st_data),
    .i_st_byte    (i_st_byte),
    .i_st_half    (i_st_half),
    .o_wb_cyc     (o_wb_cyc),
    .o_wb_stb     (o_wb_stb),
    .o_wb_we      (o_wb_we),
    .o_wb_adr     (o_wb_adr),
    .o_wb_sel     (o_wb_sel),
    .o_wb_dat     (o_wb_dat),
    .i_wb_ack     (i_wb_ack),
    .i_wb_err     (i_wb_err),
    .o_fault      (o_fault),
    .o_fault_addr (o_fault_addr),
    .o_empty      (o_empty)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] addr, input logic [31:0] data,
                             input logic b, input logic h);
    i_st_valid = 1'b1;
    i_st_addr  = addr;
    i_st_data  = data;
    i_st_byte  = b;
    i_st_half  = h;
  endtask

  task automatic check_bus(input string tag, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat);
    check({tag, ".cyc"}, o_wb_cyc, 1);
    check({tag, ".stb"}, o_wb_stb, 1);
    check({tag, ".we"},  o_wb_we,  1);
    check({tag, ".adr"}, o_wb_adr, adr);
    check({tag, ".sel"}, o_wb_sel, sel);
    check({tag, ".dat"}, o_wb_dat, dat);
  endtask

  // One store into an idle buffer: one wait-state, then ack, then the bus must go idle.
  task automatic single_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                              input logic b, input logic h, input logic [31:0] eadr,
                              input logic [3:0] esel, input logic [31:0] edat);
    check({tag, ".ready"}, o_st_ready, 1);
    drive_store(addr, data, b, h);
    tick();
    i_st_valid = 1'b0;
    check_bus(tag, eadr, esel, edat);
    check({tag, ".empty_busy"}, o_empty, 0);
    tick();
    check_bus({tag, ".hold"}, eadr, esel, edat);
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    check({tag, ".cyc_done"}, o_wb_cyc, 0);
    check({tag, ".empty_done"}, o_empty, 1);
  endtask

  initial begin
    i_reset    = 1'b1;
    i_st_valid = 1'b0;
    i_st_addr  = '0;
    i_st_data  = '0;
    i_st_byte  = 1'b0;
    i_st_half  = 1'b0;
    i_wb_ack   = 1'b0;
    i_wb_err   = 1'b0;
    tick();
    tick();
    check("rst.cyc", o_wb_cyc, 0);
    check("rst.stb", o_wb_stb, 0);
    check("rst.we", o_wb_we, 0);
    check("rst.adr", o_wb_adr, 0);
    check("rst.sel", o_wb_sel, 0);
    check("rst.dat", o_wb_dat, 0);
    check("rst.fault", o_fault, 0);
    check("rst.fault_addr", o_fault_addr, 0);
    check("rst.ready", o_st_ready, 1);
    check("rst.empty", o_empty, 1);
    i_reset = 1'b0;
    tick();

    // Formatting vectors.
    single_store("byte1", 32'h0000_1001, 32'h1234_56A5, 1'b1, 1'b0, 32'h0000_1000, SEL_B1, 32'hA5A5_A5A5);
    single_store("byte0", 32'h0000_1000, 32'hFFFF_FF3C, 1'b1, 1'b0, 32'h0000_1000, SEL_B0, 32'h3C3C_3C3C);
    single_store("byte3", 32'h0000_1003, 32'h0000_005A, 1'b1, 1'b0, 32'h0000_1000, SEL_B3, 32'h5A5A_5A5A);
    single_store("half2", 32'h0000_2002, 32'hFFFF_1234, 1'b0, 1'b1, 32'h0000_2000, 4'b1100, 32'h1234_1234);
    single_store("half1", 32'h0000_2001, 32'h0000_BEEF, 1'b0, 1'b1, 32'h0000_2000, 4'b0011, 32'hBEEF_BEEF);
    single_store("word3", 32'h0000_3003, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF);
    single_store("word11", 32'h0000_3106, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h0000_3104, 4'b1111, 32'hCAFE_F00D);

    // Fill with ack held low, third store must stall, then drain back-to-back in order.
    drive_store(32'h0000_5000, 32'h1111_1111, 1'b0, 1'b0);
    tick();
    drive_store(32'h0000_5004, 32'h2222_2222, 1'b0, 1'b0);
    tick();
    check("full.ready", o_st_ready, 0);
    check_bus("full.head", 32'h0000_5000, 4'b1111, 32'h1111_1111);
    drive_store(32'h0000_5008, 32'h3333_3333, 1'b0, 1'b0);
    tick();
    check("stall.ready", o_st_ready, 0);
    check_bus("stall.head", 32'h0000_5000, 4'b1111, 32'h1111_1111);
    i_wb_ack = 1'b1;
    tick();
    check_bus("drain.b", 32'h0000_5004, 4'b1111, 32'h2222_2222);
    check("drain.ready", o_st_ready, 1);
    tick();
    i_st_valid = 1'b0;
    check_bus("drain.c", 32'h0000_5008, 4'b1111, 32'h3333_3333);
    tick();
    i_wb_ack = 1'b0;
    check("drain.cyc", o_wb_cyc, 0);
    check("drain.empty", o_empty, 1);
    tick();
    check("drain.no_extra", o_wb_cyc, 0);

    // Error with simultaneous ack: one-cycle fault pulse, entry dropped, next store issues.
    drive_store(32'h0000_4000, 32'hAAAA_0001, 1'b0, 1'b0);
    tick();
    drive_store(32'h0000_4100, 32'hAAAA_0002, 1'b0, 1'b0);
    check_bus("err.first", 32'h0000_4000, 4'b1111, 32'hAAAA_0001);
    tick();
    i_st_valid = 1'b0;
    i_wb_err   = 1'b1;
    i_wb_ack   = 1'b1;
    tick();
    i_wb_err = 1'b0;
    i_wb_ack = 1'b0;
    check("err.fault", o_fault, 1);
    check("err.fault_addr", o_fault_addr, 32'h0000_4000);
    check_bus("err.next", 32'h0000_4100, 4'b1111, 32'hAAAA_0002);
    tick();
    check("err.pulse_end", o_fault, 0);
    check("err.addr_hold", o_fault_addr, 32'h0000_4000);
    check_bus("err.next_hold", 32'h0000_4100, 4'b1111, 32'hAAAA_0002);
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    check("err.cyc_done", o_wb_cyc, 0);
    check("err.empty", o_empty, 1);
    check("err.no_fault", o_fault, 0);

    // Reset mid-transfer with two entries buffered; the ack in the reset cycle is ignored.
    drive_store(32'h0000_6000, 32'hBBBB_0001, 1'b0, 1'b0);
    tick();
    drive_store(32'h0000_6100, 32'hBBBB_0002, 1'b0, 1'b0);
    tick();
    i_st_valid = 1'b0;
    check("rst2.pre_stb", o_wb_stb, 1);
    check("rst2.pre_ready", o_st_ready, 0);
    i_reset  = 1'b1;
    i_wb_ack = 1'b1;
    i_wb_err = 1'b1;
    tick();
    i_reset  = 1'b0;
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    check("rst2.cyc", o_wb_cyc, 0);
    check("rst2.stb", o_wb_stb, 0);
    check("rst2.ready", o_st_ready, 1);
    check("rst2.empty", o_empty, 1);
    check("rst2.fault", o_fault, 0);
    tick();
    tick();
    check("rst2.no_stale_cyc", o_wb_cyc, 0);
    check("rst2.no_stale_empty", o_empty, 1);
    check("rst2.fault_later", o_fault, 0);
    single_store("post_rst", 32'h0000_7002, 32'h0000_9876, 1'b0, 1'b1, 32'h0000_7000, 4'b1100, 32'h9876_9876);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
